// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - dual-issue fetch-to-decode instruction queue
// Circular buffer accepting up to two instructions per cycle and presenting the two oldest.
module instr_queue #(
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] in_instr1,
   input  logic [31:0] in_instr2,
   input  logic        in_finish,
   output logic        stall,
   output logic [31:0] out_instr1,
   output logic [31:0] out_instr2,
   output logic        out_valid1,
   output logic        out_valid2,
   input  logic        dispatch_en,
   output logic        done
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic          finish_seen;

   logic          v1;
   logic          v2;
   logic          push_en;
   logic [1:0]    push_n;
   logic [1:0]    pop_n;
   logic [AW-1:0] wr2_ptr;

   // Stall whenever fewer than two entries are free, so a pair push can never overflow.
   assign stall      = count > CW'(DEPTH - 2);
   assign out_valid1 = count != '0;
   assign out_valid2 = count > CW'(1);
   assign out_instr1 = out_valid1 ? mem[head] : 32'h0;
   assign out_instr2 = out_valid2 ? mem[head + AW'(1)] : 32'h0;
   assign done       = finish_seen && (count == '0);

   always_comb begin
      v1      = in_instr1 != 32'h0;
      v2      = in_instr2 != 32'h0;
      push_en = !stall && !finish_seen && !flush && !reset;
      push_n  = push_en ? ({1'b0, v1} + {1'b0, v2}) : 2'd0;
      pop_n   = 2'd0;
      if (dispatch_en) begin
         if (out_valid2)
            pop_n = 2'd2;
         else if (out_valid1)
            pop_n = 2'd1;
      end
      // Slot 2 lands directly at tail when slot 1 is empty (compaction).
      wr2_ptr = v1 ? tail + AW'(1) : tail;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         finish_seen <= 1'b0;
      end else begin
         head  <= head + AW'(pop_n);
         tail  <= tail + AW'(push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
         if (in_finish && !stall)
            finish_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         if (v1)
            mem[tail] <= in_instr1;
         if (v2)
            mem[wr2_ptr] <= in_instr2;
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue
// Directed scenarios followed by random traffic, all checked against a queue-based model.
module tb_instr_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] in_instr1;
   logic [31:0] in_instr2;
   logic        in_finish;
   logic        stall;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;
   logic        out_valid1;
   logic        out_valid2;
   logic        dispatch_en;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic [31:0] mq[$];
   bit          mfin;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_instr1   (in_instr1),
      .in_instr2   (in_instr2),
      .in_finish   (in_finish),
      .stall       (stall),
      .out_instr1  (out_instr1),
      .out_instr2  (out_instr2),
      .out_valid1  (out_valid1),
      .out_valid2  (out_valid2),
      .dispatch_en (dispatch_en),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_stall();
      return (DEPTH - mq.size()) < 2;
   endfunction

   // Reference: pop the oldest valid entries, then append nonzero fetch slots in order.
   task automatic model_edge();
      int npop;
      bit st;
      if (reset || flush) begin
         mq.delete();
         mfin = 1'b0;
      end else begin
         st   = m_stall();
         npop = dispatch_en ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
         for (int i = 0; i < npop; i++)
            void'(mq.pop_front());
         if (!st && !mfin) begin
            if (in_instr1 != 0) mq.push_back(in_instr1);
            if (in_instr2 != 0) mq.push_back(in_instr2);
         end
         if (in_finish && !st)
            mfin = 1'b1;
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".stall"},  stall,      m_stall());
      chk({tag, ".valid1"}, out_valid1, mq.size() >= 1);
      chk({tag, ".valid2"}, out_valid2, mq.size() >= 2);
      chk({tag, ".instr1"}, out_instr1, (mq.size() >= 1) ? mq[0] : 32'h0);
      chk({tag, ".instr2"}, out_instr2, (mq.size() >= 2) ? mq[1] : 32'h0);
      chk({tag, ".done"},   done,       mfin && mq.size() == 0);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic drive(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                        input logic fin, input logic disp, input logic fl);
      in_instr1   = i1;
      in_instr2   = i2;
      in_finish   = fin;
      dispatch_en = disp;
      flush       = fl;
      reset       = 1'b0;
      cycle(tag);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_instr1 = 32'h00A00093; in_instr2 = 32'h0;
      in_finish = 1'b0; dispatch_en = 1'b0;
      mq.delete(); mfin = 1'b0;
      @(negedge clk);
      cycle("reset0");
      cycle("reset1");
      chk("reset_valid1", out_valid1, 1'b0);
      chk("reset_stall", stall, 1'b0);
      chk("reset_done", done, 1'b0);

      // Fill to full, then an ignored pair.
      drive("fill1", 32'h1, 32'h2, 0, 0, 0);
      drive("fill2", 32'h3, 32'h4, 0, 0, 0);
      drive("fill3", 32'h5, 32'h6, 0, 0, 0);
      chk("fill3_stall", stall, 1'b0);
      drive("fill4", 32'h7, 32'h8, 0, 0, 0);
      chk("fill4_stall", stall, 1'b1);
      drive("fill5", 32'h9, 32'hA, 0, 0, 0);
      chk("full_out1", out_instr1, 32'h1);
      chk("full_out2", out_instr2, 32'h2);

      // Drain with one refill of (9,A) once space appears; checks wrap order.
      begin
         bit pushed = 1'b0;
         for (int i = 0; i < 5; i++) begin
            if (!m_stall() && !pushed) begin
               drive("drain", 32'h9, 32'hA, 0, 1, 0);
               pushed = 1'b1;
            end else
               drive("drain", 32'h0, 32'h0, 0, 1, 0);
         end
         chk("drain_empty", out_valid1, 1'b0);
      end

      // Compaction of an odd pair.
      drive("flush_a", 32'h0, 32'h0, 0, 0, 1);
      drive("odd1", 32'h0, 32'h11, 0, 0, 0);
      drive("odd2", 32'h22, 32'h33, 0, 0, 0);
      chk("odd_out1", out_instr1, 32'h11);
      chk("odd_out2", out_instr2, 32'h22);
      drive("odd_pop", 32'h0, 32'h0, 0, 1, 0);
      chk("odd_tail1", out_instr1, 32'h33);
      chk("odd_tail2", out_instr2, 32'h0);
      chk("odd_tailv2", out_valid2, 1'b0);

      // Finish: later pushes dropped, done after drain and sticky.
      drive("flush_b", 32'h0, 32'h0, 0, 0, 1);
      drive("fin1", 32'h5, 32'h6, 1, 0, 0);
      drive("fin2", 32'h7, 32'h8, 0, 0, 0);
      chk("fin_done0", done, 1'b0);
      chk("fin_v2", out_instr2, 32'h6);
      drive("fin_pop", 32'h0, 32'h0, 0, 1, 0);
      chk("fin_done1", done, 1'b1);
      for (int i = 0; i < 3; i++)
         drive("fin_hold", 32'h7, 32'h8, 0, 1, 0);
      chk("fin_done_sticky", done, 1'b1);

      // Flush with count=5 and finish seen.
      drive("flush_c", 32'h0, 32'h0, 0, 0, 1);
      drive("mf1", 32'h1, 32'h2, 0, 0, 0);
      drive("mf2", 32'h3, 32'h4, 0, 0, 0);
      drive("mf3", 32'h5, 32'h0, 1, 0, 0);
      drive("mf_flush", 32'hE, 32'hF, 0, 0, 1);
      chk("mf_valid1", out_valid1, 1'b0);
      chk("mf_done", done, 1'b0);
      drive("mf_push", 32'h1, 32'h2, 0, 0, 0);
      chk("mf_push1", out_instr1, 32'h1);
      chk("mf_push2", out_instr2, 32'h2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         in_instr1   = ($urandom_range(0, 9) < 3) ? 32'h0 : $urandom;
         in_instr2   = ($urandom_range(0, 9) < 3) ? 32'h0 : $urandom;
         in_finish   = $urandom_range(0, 99) < 2;
         dispatch_en = $urandom_range(0, 9) < 5;
         flush       = $urandom_range(0, 99) < 3;
         reset       = $urandom_range(0, 199) < 1;
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
